// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: counter states, BTB entry layout,
// default geometry and a helper that maps a counter state to a direction.
// Optional build macro: BP_GSHARE_EN (gshare counter indexing).
package branch_predictor_pkg;

    localparam int DEF_ENTRIES = 16;
    localparam int DEF_HIST_W  = 4;

    // Tags are stored at their widest possible size (pc[31:3] for the
    // smallest table plus one spare bit) and zero-extended, so the entry
    // layout does not depend on ENTRIES.
    localparam int TAG_MAX_W   = 30;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_state_t;

    // Target-side half of a BTB entry. The 2-bit direction counter lives in
    // its own table because with gshare it is indexed differently.
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

    function automatic logic cnt_is_taken(cnt_state_t s);
        return (s == WT) || (s == ST);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute side connection to the branch predictor.
// master: the pipeline (drives lookup PC, resolved-branch updates, clear).
// slave : the predictor (returns prediction and mispredict count).
// Update semantics: upd_valid is a single-cycle strobe already qualified by
// stall; there is no ready, every presented update is accepted at the edge.
interface branch_predictor_if;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_mispredict;
    logic        clear;
    logic [31:0] mispredict_count;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_target, upd_taken,
               upd_mispredict, clear,
        input  pred_hit, pred_taken, pred_target, mispredict_count
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_target, upd_taken,
               upd_mispredict, clear,
        output pred_hit, pred_taken, pred_target, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  cnt_state_t cur,
    input  logic       taken,
    output cnt_state_t nxt
);

    // Step toward ST on taken, toward SNT on not-taken, holding at the ends.
    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = cnt_state_t'(cur + 2'b01);
        end else begin
            if (cur != SNT) nxt = cnt_state_t'(cur - 2'b01);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and a saturating
// mispredict counter. Lookup is combinational; updates land on the next
// rising CLK edge with no bypass to a same-cycle lookup.
// Optional build macro: BP_GSHARE_EN -- counters are indexed by the PC
// index XOR a non-speculative global history of HIST_W bits.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int HIST_W  = DEF_HIST_W
) (
    input  logic              CLK,
    input  logic              nRST,
    branch_predictor_if.slave bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    btb_entry_t  btb_q [ENTRIES];
    cnt_state_t  cnt_q [ENTRIES];
    logic [31:0] mispredict_q;

    logic [IDX_W-1:0]     lk_idx;
    logic [IDX_W-1:0]     lk_cidx;
    logic [TAG_MAX_W-1:0] lk_tag;
    logic [IDX_W-1:0]     up_idx;
    logic [IDX_W-1:0]     up_cidx;
    logic [TAG_MAX_W-1:0] up_tag;
    logic                 up_hit;
    cnt_state_t           up_cnt_nxt;
    btb_entry_t           lk_entry;

    // Word-aligned PCs: bits [1:0] never participate in index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0]};

    assign lk_idx = bp.lookup_pc[IDX_W+1:2];
    assign up_idx = bp.upd_pc[IDX_W+1:2];
    assign lk_tag = TAG_MAX_W'(bp.lookup_pc[31:IDX_W+2]);
    assign up_tag = TAG_MAX_W'(bp.upd_pc[31:IDX_W+2]);

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] hist_q;
    logic [IDX_W-1:0]  hist_ext;

    // Zero-extend the history to index width before hashing.
    always_comb begin
        hist_ext = '0;
        hist_ext[HIST_W-1:0] = hist_q;
    end

    assign lk_cidx = lk_idx ^ hist_ext;
    assign up_cidx = up_idx ^ hist_ext;

    // Shift in each resolved direction; history follows committed branches only.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) hist_q <= '0;
        else if (bp.upd_valid) hist_q <= HIST_W'({hist_q, bp.upd_taken});
    end
`else
    // Without gshare the counter shares the BTB entry's index.
    logic [HIST_W-1:0] unused_hist;
    assign unused_hist = '0;
    assign lk_cidx = lk_idx;
    assign up_cidx = up_idx;
`endif

    // Combinational lookup: hit on valid+tag, direction from the counter.
    always_comb begin
        lk_entry       = btb_q[lk_idx];
        bp.pred_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
        bp.pred_taken  = bp.pred_hit && cnt_is_taken(cnt_q[lk_cidx]);
        bp.pred_target = bp.pred_taken ? lk_entry.target : (bp.lookup_pc + 32'd4);
    end

    assign up_hit = btb_q[up_idx].valid && (btb_q[up_idx].tag == up_tag);

    sat_counter2 u_cnt (
        .cur   (cnt_q[up_cidx]),
        .taken (bp.upd_taken),
        .nxt   (up_cnt_nxt)
    );

    // BTB and counter tables: clear beats update; a taken miss allocates.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '0;
                cnt_q[i] <= WNT;
            end
        end else if (bp.clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i].valid <= 1'b0;
            end
        end else if (bp.upd_valid) begin
            if (up_hit) begin
                cnt_q[up_cidx] <= up_cnt_nxt;
                if (bp.upd_taken) btb_q[up_idx].target <= bp.upd_target;
            end else if (bp.upd_taken) begin
                btb_q[up_idx].valid  <= 1'b1;
                btb_q[up_idx].tag    <= up_tag;
                btb_q[up_idx].target <= bp.upd_target;
                cnt_q[up_cidx]       <= WT;
            end
        end
    end

    // Mispredict counter saturates at all-ones; clear does not touch it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mispredict_q <= '0;
        end else if (bp.upd_valid && bp.upd_mispredict && (mispredict_q != 32'hFFFF_FFFF)) begin
            mispredict_q <= mispredict_q + 32'd1;
        end
    end

    assign bp.mispredict_count = mispredict_q;

    logic [TAG_W-1:0] unused_tag_w;
    assign unused_tag_w = '0;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16: index pc[5:2], tag pc[31:6]).
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic CLK;
    logic nRST;
    int   n_vec;
    int   n_miss;
    logic [31:0] exp_cnt;

    branch_predictor_if bp();

    branch_predictor #(.ENTRIES(16), .HIST_W(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bp   (bp.slave)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one resolved branch for exactly one rising edge.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic mis, input logic clr);
        @(negedge CLK);
        bp.upd_valid      = 1'b1;
        bp.upd_pc         = pc;
        bp.upd_taken      = tk;
        bp.upd_target     = tgt;
        bp.upd_mispredict = mis;
        bp.clear          = clr;
        @(negedge CLK);
        bp.upd_valid      = 1'b0;
        bp.upd_mispredict = 1'b0;
        bp.clear          = 1'b0;
        if (mis && (exp_cnt != 32'hFFFF_FFFF)) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] tgt);
        bp.lookup_pc = pc;
        #1;
        chk({tag, ".hit"},    {31'd0, bp.pred_hit},   {31'd0, hit});
        chk({tag, ".taken"},  {31'd0, bp.pred_taken}, {31'd0, tk});
        chk({tag, ".target"}, bp.pred_target,         tgt);
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        exp_cnt = 32'd0;
        nRST = 1'b0;
        bp.lookup_pc = 32'h40;
        bp.upd_valid = 1'b0;
        bp.upd_pc = '0;
        bp.upd_target = '0;
        bp.upd_taken = 1'b0;
        bp.upd_mispredict = 1'b0;
        bp.clear = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        look("in_reset", 32'h40, 1'b0, 1'b0, 32'h44);
        chk("in_reset.cnt", bp.mispredict_count, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);
        look("post_reset", 32'h40, 1'b0, 1'b0, 32'h44);

        // Not-taken miss leaves BTB unchanged
        upd(32'h40, 1'b0, 32'h80, 1'b0, 1'b0);
        look("nt_miss", 32'h40, 1'b0, 1'b0, 32'h44);

        // Taken miss allocates at WT
        upd(32'h40, 1'b1, 32'h80, 1'b1, 1'b0);
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h80);
        chk("alloc.cnt", bp.mispredict_count, exp_cnt);

        // Same-cycle lookup of an entry being allocated sees old contents
        @(negedge CLK);
        bp.lookup_pc = 32'h44;
        bp.upd_valid = 1'b1;
        bp.upd_pc = 32'h44;
        bp.upd_taken = 1'b1;
        bp.upd_target = 32'h100;
        #1;
        chk("nobypass.hit", {31'd0, bp.pred_hit}, 32'd0);
        chk("nobypass.target", bp.pred_target, 32'h48);
        @(negedge CLK);
        bp.upd_valid = 1'b0;
        look("after_bypass", 32'h44, 1'b1, 1'b1, 32'h100);

        // Counter walk on 0x40: WT->ST->WT->WNT->SNT->SNT->WNT->WT
        upd(32'h40, 1'b1, 32'h90, 1'b0, 1'b0);
        look("st", 32'h40, 1'b1, 1'b1, 32'h90);
        upd(32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        look("st_wt", 32'h40, 1'b1, 1'b1, 32'h90);
        upd(32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        look("wt_wnt", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        look("wnt_snt", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        look("snt_hold", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'hB0, 1'b1, 1'b0);
        look("snt_wnt", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'hA0, 1'b1, 1'b0);
        look("wnt_wt", 32'h40, 1'b1, 1'b1, 32'hA0);
        chk("walk.cnt", bp.mispredict_count, exp_cnt);

        // Aliasing: 0x80 shares index 0, replaces 0x40 and restarts at WT
        upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        upd(32'h80, 1'b1, 32'hC0, 1'b0, 1'b0);
        look("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
        look("alias_new", 32'h80, 1'b1, 1'b1, 32'hC0);
        look("other_idx", 32'h44, 1'b1, 1'b1, 32'h100);

        // Mispredict flag without upd_valid is ignored
        @(negedge CLK);
        bp.upd_mispredict = 1'b1;
        @(negedge CLK);
        bp.upd_mispredict = 1'b0;
        chk("mis_novalid.cnt", bp.mispredict_count, exp_cnt);

        // Clear wins over a simultaneous taken update; count keeps going
        upd(32'h40, 1'b1, 32'hD0, 1'b1, 1'b1);
        look("clear_40", 32'h40, 1'b0, 1'b0, 32'h44);
        look("clear_80", 32'h80, 1'b0, 1'b0, 32'h84);
        look("clear_44", 32'h44, 1'b0, 1'b0, 32'h48);
        chk("clear.cnt", bp.mispredict_count, exp_cnt);

        // Reset asserted across an update edge discards the update
        @(negedge CLK);
        bp.upd_valid = 1'b1;
        bp.upd_pc = 32'h48;
        bp.upd_taken = 1'b1;
        bp.upd_target = 32'hE0;
        bp.upd_mispredict = 1'b1;
        #2;
        nRST = 1'b0;
        @(negedge CLK);
        bp.upd_valid = 1'b0;
        bp.upd_mispredict = 1'b0;
        nRST = 1'b1;
        exp_cnt = 32'd0;
        look("rst_mid", 32'h48, 1'b0, 1'b0, 32'h4C);
        chk("rst_mid.cnt", bp.mispredict_count, exp_cnt);

        // Saturation: preload near the top, then 5 mispredicts
        @(negedge CLK);
        force dut.mispredict_q = 32'hFFFF_FFFD;
        @(negedge CLK);
        release dut.mispredict_q;
        exp_cnt = 32'hFFFF_FFFD;
        chk("sat.preload", bp.mispredict_count, exp_cnt);
        upd(32'h200, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("sat.fffe", bp.mispredict_count, 32'hFFFF_FFFE);
        upd(32'h200, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("sat.ffff", bp.mispredict_count, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) upd(32'h200, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("sat.hold", bp.mispredict_count, 32'hFFFF_FFFF);
        chk("sat.model", bp.mispredict_count, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16: number of BTB entries; power of two, 2..256; IDX_W = log2(ENTRIES).
REQ-002 The block SHALL have parameter HIST_W, default 4: global history bits; 1..IDX_W; used only when BP_GSHARE_EN is defined.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port lookup_pc, input, 32 bits: fetch-stage PC.
REQ-006 The block SHALL have port pred_hit, output, 1 bit: valid entry with matching tag.
REQ-007 The block SHALL have port pred_taken, output, 1 bit: pred_hit AND counter in WT or ST.
REQ-008 The block SHALL have port pred_target, output, 32 bits: stored target when pred_taken, else lookup_pc+4.
REQ-009 The block SHALL have port upd_valid, input, 1 bit: a resolved branch is presented this cycle (EX stage, already qualified by stall).
REQ-010 The block SHALL have ports upd_pc and upd_target, input, 32 bits each: PC and computed target of the resolved branch.
REQ-011 The block SHALL have port upd_taken, input, 1 bit: resolved branch direction.
REQ-012 The block SHALL have port upd_mispredict, input, 1 bit: the fetch-time prediction was wrong.
REQ-013 The block SHALL have port clear, input, 1 bit: synchronous invalidate-all.
REQ-014 The block SHALL have port mispredict_count, output, 32 bits: saturating count of mispredicts.

Function
REQ-015 Index SHALL be pc[IDX_W+1:2], and tag SHALL be pc[31:IDX_W+2]; pc[1:0] is ignored.
REQ-016 Lookup SHALL be purely combinational: zero-cycle latency from lookup_pc to pred_* outputs.
REQ-017 Each entry SHALL hold a valid bit, a tag, a 32-bit target and a 2-bit counter with states SNT(00), WNT(01), WT(10), ST(11).
REQ-018 Counter update SHALL be: taken increments, saturating at ST; not-taken decrements, saturating at SNT.
REQ-019 On upd_valid with a hit at the update index, the block SHALL update the counter and, when upd_taken, overwrite the target.
REQ-020 On upd_valid with a miss and upd_taken=1, the block SHALL allocate the entry: valid=1, tag, target and counter=WT, replacing any occupant.
REQ-021 On upd_valid with a miss and upd_taken=0, the BTB SHALL be left unchanged.
REQ-022 Updates SHALL take effect at the next rising edge; a same-cycle lookup of the index being updated returns pre-update contents (no bypass).
REQ-023 mispredict_count SHALL increment on each cycle with upd_valid AND upd_mispredict, and SHALL hold at 0xFFFFFFFF.
REQ-024 clear SHALL zero all valid bits at the next edge and take priority over a simultaneous update; counters, targets and mispredict_count are unaffected.

Reset
REQ-025 While nRST=0, the block SHALL hold all valid bits at 0, all counters at WNT, all targets at 0, mispredict_count at 0 and history at 0.
REQ-026 During reset, pred_hit=0, pred_taken=0 and pred_target=lookup_pc+4; reset asserted mid-update SHALL discard that update.

Configuration
REQ-027 When BP_GSHARE_EN is defined, the counter index for lookup and update SHALL be the PC index XOR the zero-extended HIST_W-bit global history, and the tag/target remain PC-indexed in a separate table.
REQ-028 When BP_GSHARE_EN is defined, the history SHALL shift left on each upd_valid, inserting upd_taken at bit 0 (non-speculative).
REQ-029 When BP_GSHARE_EN is not defined, the block SHALL have no history register, and counters SHALL share the PC index with the BTB entry.

Structure
REQ-030 The counter-state enum, the entry struct and the default ENTRIES/HIST_W constants SHALL live in a shared package alongside the existing CPU types package.
REQ-031 The 2-bit counter next-state function SHALL be one sub-module, sat_counter2.

Verification
REQ-032 After reset, lookup_pc=0x40 SHALL give pred_hit=0, pred_taken=0 and pred_target=0x44.
REQ-033 Update pc=0x40, taken=1, target=0x80, then lookup 0x40 SHALL give hit=1, taken=1 (WT) and target=0x80.
REQ-034 Two not-taken updates of pc=0x40 SHALL move the counter WT->WNT->SNT and give pred_taken=0; a third not-taken update SHALL leave it at SNT.
REQ-035 With ENTRIES=16, allocating pc 0x40 and then pc 0x80 (same index, different tag) SHALL make lookup 0x40 miss.
REQ-036 Simultaneous clear and taken update of 0x40 SHALL leave lookup 0x40 missing on the next cycle.
REQ-037 2^32+5 mispredict updates SHALL leave mispredict_count at 0xFFFFFFFF; the bench may force the counter near saturation.
